// File: rtl/dds_poly_ctrl_pkg.sv
// Shared definitions for the DDS polynomial sequencer: state encoding,
// coefficient-select encodings and the fixed datapath latency.
package dds_poly_ctrl_pkg;

  localparam int PIPE_LAT = 2;

  localparam logic [1:0] COEF_A0  = 2'd0;
  localparam logic [1:0] COEF_A1  = 2'd1;
  localparam logic [1:0] COEF_A2  = 2'd2;
  localparam logic [1:0] COEF_INV = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic coef_sel_ok(input logic [1:0] sel);
    return (sel != COEF_INV);
  endfunction

endpackage

// File: rtl/dds_coef_table.sv
// Per-segment a0/a1/a2 coefficient register file: synchronous write,
// asynchronous read of one segment's three coefficients.
module dds_coef_table
  import dds_poly_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEG_BITS   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  we,
  input  logic [SEG_BITS-1:0]   wseg,
  input  logic [1:0]            wsel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [SEG_BITS-1:0]   rseg,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [DATA_WIDTH-1:0] a1,
  output logic [DATA_WIDTH-1:0] a2
);

  localparam int NSEG = 1 << SEG_BITS;

  logic [NSEG-1:0][DATA_WIDTH-1:0] a0_q, a0_d;
  logic [NSEG-1:0][DATA_WIDTH-1:0] a1_q, a1_d;
  logic [NSEG-1:0][DATA_WIDTH-1:0] a2_q, a2_d;

  // Next-state of the table: one coefficient replaced per accepted write
  always_comb begin
    a0_d = a0_q;
    a1_d = a1_q;
    a2_d = a2_q;
    if (we) begin
      case (wsel)
        COEF_A0: a0_d[wseg] = wdata;
        COEF_A1: a1_d[wseg] = wdata;
        COEF_A2: a2_d[wseg] = wdata;
        default: a0_d = a0_q;
      endcase
    end else begin
      a0_d = a0_q;
    end
  end

  // Table storage, cleared by reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a0_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
    end else begin
      a0_q <= a0_d;
      a1_q <= a1_d;
      a2_q <= a2_d;
    end
  end

  assign a0 = a0_q[rseg];
  assign a1 = a1_q[rseg];
  assign a2 = a2_q[rseg];

endmodule

// File: rtl/dds_poly_ctrl.sv
// DDS sine-path sequencer: phase accumulator, segment/offset split, coefficient
// fetch and validity tracking across the two-register Horner datapath.
module dds_poly_ctrl
  import dds_poly_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int I_widthX    = 2,
  parameter int SEG_BITS    = 4,
  parameter int PHASE_WIDTH = 24
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   run,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic                   cfg_we,
  input  logic [SEG_BITS+1:0]    cfg_addr,
  input  logic [DATA_WIDTH-1:0]  cfg_wdata,
  output logic                   cfg_err,
  output logic                   dp_enable,
  output logic [DATA_WIDTH-1:0]  x_argu,
  output logic [DATA_WIDTH-1:0]  a0_out,
  output logic [DATA_WIDTH-1:0]  a1_out,
  output logic [DATA_WIDTH-1:0]  a2_out,
  input  logic [DATA_WIDTH-1:0]  eval_in,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int OFF_BITS = PHASE_WIDTH - SEG_BITS;
  localparam int XF_BITS  = DATA_WIDTH - I_widthX;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] fcw_q, fcw_d;
  logic [PIPE_LAT-1:0]    vld_q, vld_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   advance_s;
  logic                   busy_s;
  logic                   issue_s;
  logic                   cfg_accept_s;
  logic [SEG_BITS-1:0]    seg_s;
  logic [SEG_BITS-1:0]    cfg_seg_s;
  logic [1:0]             cfg_sel_s;
  logic [XF_BITS-1:0]     x_frac_s;

  // A stalled head sample freezes phase, valid pipe and datapath together
  assign advance_s = ~(vld_q[PIPE_LAT-1] & ~out_ready);
  assign busy_s    = (state_q != IDLE);
  assign cfg_seg_s = cfg_addr[SEG_BITS+1:2];
  assign cfg_sel_s = cfg_addr[1:0];
  assign seg_s     = phase_q[PHASE_WIDTH-1 -: SEG_BITS];

  // Sequencing: state transitions, phase stepping, valid pipe and config check
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    fcw_d        = fcw_q;
    vld_d        = vld_q;
    issue_s      = (state_q == RUN) & run & advance_s;
    cfg_accept_s = cfg_we & (state_q == IDLE) & coef_sel_ok(cfg_sel_s);
    cfg_err_d    = cfg_we & ~cfg_accept_s;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = RUN;
          phase_d = {PHASE_WIDTH{1'b0}};
          fcw_d   = fcw;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        state_d = run ? RUN : DRAIN;
        if (issue_s) begin
          phase_d = phase_q + fcw_q;
        end else begin
          phase_d = phase_q;
        end
      end
      DRAIN: begin
        if (run) begin
          state_d = RUN;
        end else if (vld_q == {PIPE_LAT{1'b0}}) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy_s & advance_s) begin
      vld_d = {vld_q[PIPE_LAT-2:0], issue_s};
    end else begin
      vld_d = vld_q;
    end
  end

  // Sequencer registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      phase_q   <= {PHASE_WIDTH{1'b0}};
      fcw_q     <= {PHASE_WIDTH{1'b0}};
      vld_q     <= {PIPE_LAT{1'b0}};
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      fcw_q     <= fcw_d;
      vld_q     <= vld_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Offset bits below the segment index form the unsigned fraction of x
  if (OFF_BITS >= XF_BITS) begin : g_x_trunc
    assign x_frac_s = phase_q[OFF_BITS-1 -: XF_BITS];
  end else begin : g_x_pad
    assign x_frac_s = {phase_q[OFF_BITS-1:0], {(XF_BITS-OFF_BITS){1'b0}}};
  end

  dds_coef_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEG_BITS   (SEG_BITS)
  ) u_coef_table (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .we     (cfg_accept_s),
    .wseg   (cfg_seg_s),
    .wsel   (cfg_sel_s),
    .wdata  (cfg_wdata),
    .rseg   (seg_s),
    .a0     (a0_out),
    .a1     (a1_out),
    .a2     (a2_out)
  );

  assign x_argu       = {{I_widthX{1'b0}}, x_frac_s};
  assign dp_enable    = busy_s & advance_s;
  assign busy         = busy_s;
  assign sample_valid = vld_q[PIPE_LAT-1];
  assign sample_out   = eval_in;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_dds_poly_ctrl.sv
// Self-checking bench: a behavioural Horner datapath feeds eval_in, and every
// transferred sample n is compared with the polynomial at phase n*fcw.
module tb_dds_poly_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        run;
  logic [23:0] fcw;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_err;
  logic        dp_enable;
  logic [15:0] x_argu, a0_out, a1_out, a2_out;
  logic [15:0] eval_in;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        out_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] tbl_a0 [16];
  logic [15:0] tbl_a1 [16];
  logic [15:0] tbl_a2 [16];
  logic [15:0] got_q [$];
  logic [23:0] last_phase;

  dds_poly_ctrl dut (
    .clk_in (clk_in), .rst_in (rst_in), .run (run), .fcw (fcw),
    .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata),
    .cfg_err (cfg_err), .dp_enable (dp_enable), .x_argu (x_argu),
    .a0_out (a0_out), .a1_out (a1_out), .a2_out (a2_out),
    .eval_in (eval_in), .sample_out (sample_out), .sample_valid (sample_valid),
    .out_ready (out_ready), .busy (busy)
  );

  always #5 clk_in = ~clk_in;

  // One Horner step in Q2.14: ((a * x) >> 14) + c, truncated to 16 bits
  function automatic logic [15:0] horner_step(input logic [15:0] x, input logic [15:0] c,
                                              input logic [15:0] a);
    logic [31:0] t;
    t = {16'd0, a} * {16'd0, x};
    return t[29:14] + c;
  endfunction

  function automatic logic [23:0] phase_of(input int n, input logic [23:0] f);
    logic [23:0] nn;
    nn = n[23:0];
    return nn * f;
  endfunction

  function automatic logic [15:0] x_of(input logic [23:0] ph);
    return {2'b00, ph[19:6]};
  endfunction

  function automatic logic [15:0] exp_sample(input int n, input logic [23:0] f);
    logic [23:0] ph;
    logic [3:0]  s;
    logic [15:0] x;
    ph = phase_of(n, f);
    s  = ph[23:20];
    x  = x_of(ph);
    return horner_step(x, tbl_a0[s], horner_step(x, tbl_a1[s], tbl_a2[s]));
  endfunction

  // Behavioural two-register datapath driven by dp_enable
  logic [15:0] s1_p1, s1_x, s1_a0, s2_y;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_p1 <= 16'd0; s1_x <= 16'd0; s1_a0 <= 16'd0; s2_y <= 16'd0;
    end else if (dp_enable) begin
      s1_p1 <= horner_step(x_argu, a1_out, a2_out);
      s1_x  <= x_argu;
      s1_a0 <= a0_out;
      s2_y  <= horner_step(s1_x, s1_a0, s1_p1);
    end
  end
  assign eval_in = s2_y;

  // Record every sample handed over to the consumer
  always @(negedge clk_in) begin
    if (!rst_in && sample_valid && out_ready) got_q.push_back(sample_out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_tbl();
    for (int s = 0; s < 16; s++) begin
      tbl_a0[s] = 16'd0; tbl_a1[s] = 16'd0; tbl_a2[s] = 16'd0;
    end
  endtask

  task automatic load_table(input bit seq_a0);
    logic [15:0] v;
    for (int s = 0; s < 16; s++) begin
      for (int sel = 0; sel < 3; sel++) begin
        v = (sel == 0 && seq_a0) ? 16'((s + 1) * 256) : 16'($urandom);
        cfg_we = 1'b1; cfg_addr = {s[3:0], sel[1:0]}; cfg_wdata = v;
        case (sel)
          0: tbl_a0[s] = v;
          1: tbl_a1[s] = v;
          default: tbl_a2[s] = v;
        endcase
        tick();
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic drain_wait(output bit to);
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (!busy) begin to = 1'b0; break; end
      tick();
    end
  endtask

  task automatic run_session(input logic [23:0] f, input int n_target, input bit rnd,
                             output int fv, output int nd, output bit to);
    bit dto;
    got_q.delete(); fv = -1; nd = -1; to = 1'b0;
    fcw = f; run = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 1000 && nd < 0; c++) begin
      @(negedge clk_in);
      if (sample_valid && fv < 0) fv = c;
      tick();
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (got_q.size() >= n_target) begin
        nd = got_q.size(); run = 1'b0; out_ready = 1'b1;
      end
    end
    if (nd < 0) begin to = 1'b1; run = 1'b0; out_ready = 1'b1; end
    drain_wait(dto);
    to = to | dto;
    last_phase = phase_of(got_q.size(), f);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; run = 1'b0; fcw = 24'd0; cfg_we = 1'b0;
    cfg_addr = 6'd0; cfg_wdata = 16'd0; out_ready = 1'b1;
    clear_tbl(); got_q.delete(); last_phase = 24'd0;
    repeat (3) tick();
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    checks++; if (dp_enable !== 1'b0) begin errors++; $display("FAIL reset_dp_enable got=%b exp=0", dp_enable); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (x_argu !== 16'd0) begin errors++; $display("FAIL reset_x got=%h exp=0", x_argu); end
    checks++; if ({a0_out, a1_out, a2_out} !== 48'd0) begin errors++; $display("FAIL reset_coef got=%h exp=0", {a0_out, a1_out, a2_out}); end
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL reset_sample got=%h exp=0", sample_out); end
    tick();
  endtask

  task automatic test_basic();
    int fv, nd; bit to;
    load_table(1'b1);
    run_session(24'h010000, 40, 1'b0, fv, nd, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (fv !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", fv); end
    checks++; if (got_q.size() !== nd + 2) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), nd + 2); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_sample(i, 24'h010000)) begin
        errors++; $display("FAIL basic_sample[%0d] got=%h exp=%h", i, got_q[i], exp_sample(i, 24'h010000));
      end
    end
  endtask

  task automatic test_drain();
    int fv, nd; bit to; logic [23:0] f;
    f = 24'($urandom);
    run_session(f, 10, 1'b0, fv, nd, to);
    checks++; if (to) begin errors++; $display("FAIL drain_timeout got=1 exp=0"); end
    checks++; if (nd !== 10) begin errors++; $display("FAIL drain_drop_point got=%0d exp=10", nd); end
    checks++; if (got_q.size() !== 12) begin errors++; $display("FAIL drain_total got=%0d exp=12", got_q.size()); end
    @(negedge clk_in);
    checks++; if ({busy, dp_enable, sample_valid} !== 3'b000) begin errors++; $display("FAIL drain_idle got=%b exp=000", {busy, dp_enable, sample_valid}); end
    tick();
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_sample(i, f)) begin
        errors++; $display("FAIL drain_sample[%0d] got=%h exp=%h", i, got_q[i], exp_sample(i, f));
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] f; int k; bit to;
    load_table(1'b0);
    f = 24'($urandom);
    got_q.delete(); fcw = f; run = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 100 && got_q.size() < 6; c++) tick();
    k = got_q.size();
    checks++; if (k < 6) begin errors++; $display("FAIL stall_fill got=%0d exp>=6", k); end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_in);
      checks++; if ({dp_enable, sample_valid} !== 2'b01) begin errors++; $display("FAIL stall_ctrl[%0d] got=%b exp=01", s, {dp_enable, sample_valid}); end
      checks++; if (x_argu !== x_of(phase_of(k + 2, f))) begin errors++; $display("FAIL stall_x[%0d] got=%h exp=%h", s, x_argu, x_of(phase_of(k + 2, f))); end
      checks++; if (sample_out !== exp_sample(k, f)) begin errors++; $display("FAIL stall_head[%0d] got=%h exp=%h", s, sample_out, exp_sample(k, f)); end
      tick();
    end
    checks++; if (got_q.size() !== k) begin errors++; $display("FAIL stall_no_xfer got=%0d exp=%0d", got_q.size(), k); end
    out_ready = 1'b1;
    for (int c = 0; c < 100 && got_q.size() < 16; c++) tick();
    run = 1'b0;
    drain_wait(to);
    checks++; if (to) begin errors++; $display("FAIL stall_drain_timeout got=1 exp=0"); end
    last_phase = phase_of(got_q.size(), f);
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_sample(i, f)) begin
        errors++; $display("FAIL stall_sample[%0d] got=%h exp=%h", i, got_q[i], exp_sample(i, f));
      end
    end
  endtask

  task automatic test_fcw_max();
    int fv, nd; bit to;
    run_session(24'hFFFFFF, 20, 1'b0, fv, nd, to);
    checks++; if (to) begin errors++; $display("FAIL fcwmax_timeout got=1 exp=0"); end
    checks++; if (got_q.size() !== nd + 2) begin errors++; $display("FAIL fcwmax_count got=%0d exp=%0d", got_q.size(), nd + 2); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_sample(i, 24'hFFFFFF)) begin
        errors++; $display("FAIL fcwmax_sample[%0d] got=%h exp=%h", i, got_q[i], exp_sample(i, 24'hFFFFFF));
      end
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] seg; logic [15:0] v; bit to;
    seg = last_phase[23:20];
    cfg_we = 1'b1; cfg_addr = {seg, 2'b11}; cfg_wdata = 16'($urandom);
    tick();
    cfg_we = 1'b0;
    @(negedge clk_in);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_sel3_err got=%b exp=1", cfg_err); end
    checks++; if ({a0_out, a1_out, a2_out} !== {tbl_a0[seg], tbl_a1[seg], tbl_a2[seg]}) begin
      errors++; $display("FAIL cfg_sel3_table got=%h exp=%h", {a0_out, a1_out, a2_out}, {tbl_a0[seg], tbl_a1[seg], tbl_a2[seg]});
    end
    tick();
    @(negedge clk_in);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_pulse_width got=%b exp=0", cfg_err); end
    tick();
    // write while running must be dropped
    got_q.delete(); fcw = 24'h000321; run = 1'b1;
    repeat (4) tick();
    cfg_we = 1'b1; cfg_addr = {4'd0, 2'b00}; cfg_wdata = ~tbl_a0[0];
    tick();
    cfg_we = 1'b0;
    @(negedge clk_in);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_busy_err got=%b exp=1", cfg_err); end
    tick();
    repeat (10) tick();
    run = 1'b0;
    drain_wait(to);
    checks++; if (to) begin errors++; $display("FAIL cfg_busy_timeout got=1 exp=0"); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_sample(i, 24'h000321)) begin
        errors++; $display("FAIL cfg_busy_sample[%0d] got=%h exp=%h", i, got_q[i], exp_sample(i, 24'h000321));
      end
    end
    // write on the IDLE->RUN cycle is still accepted
    v = 16'($urandom);
    got_q.delete();
    cfg_we = 1'b1; cfg_addr = {4'd0, 2'b00}; cfg_wdata = v; fcw = 24'h000777; run = 1'b1;
    tbl_a0[0] = v;
    tick();
    cfg_we = 1'b0;
    @(negedge clk_in);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_start_err got=%b exp=0", cfg_err); end
    tick();
    repeat (12) tick();
    run = 1'b0;
    drain_wait(to);
    checks++; if (got_q.size() < 10) begin errors++; $display("FAIL cfg_start_count got=%0d exp>=10", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_sample(i, 24'h000777)) begin
        errors++; $display("FAIL cfg_start_sample[%0d] got=%h exp=%h", i, got_q[i], exp_sample(i, 24'h000777));
      end
    end
    last_phase = phase_of(got_q.size(), 24'h000777);
  endtask

  task automatic test_random();
    int fv, nd; bit to; logic [23:0] f;
    load_table(1'b0);
    f = 24'($urandom);
    run_session(f, 60, 1'b1, fv, nd, to);
    checks++; if (to) begin errors++; $display("FAIL random_timeout got=1 exp=0"); end
    checks++; if (got_q.size() < 60) begin errors++; $display("FAIL random_count got=%0d exp>=60", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_sample(i, f)) begin
        errors++; $display("FAIL random_sample[%0d] got=%h exp=%h", i, got_q[i], exp_sample(i, f));
      end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); fcw = 24'($urandom); run = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 50 && !(sample_valid && got_q.size() >= 2); c++) tick();
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL rstmid_precond got=%b exp=1", sample_valid); end
    #2;
    rst_in = 1'b1;
    #1;
    checks++; if ({busy, sample_valid, dp_enable, cfg_err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_ctrl got=%b exp=0000", {busy, sample_valid, dp_enable, cfg_err});
    end
    checks++; if ({x_argu, a0_out, a1_out, a2_out, sample_out} !== 80'd0) begin
      errors++; $display("FAIL rstmid_data got=%h exp=0", {x_argu, a0_out, a1_out, a2_out, sample_out});
    end
    clear_tbl();
    run = 1'b0;
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=0", busy); end
    tick();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_drain();
    test_stall();
    test_fcw_max();
    test_cfg_err();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
